uart_transceiver: RTL

- DUT-side 8N1 UART serial endpoint; the logic at the far end of the PC-side UART bench model's serial lines.
- Serialises bytes from an internal valid/ready stream onto txd.
- Deserialises rxd into a valid/ready stream, with start-bit glitch rejection, framing-error and overrun reporting.
- Sits between the CPU's UART register/bus adapter and the board pins; self-timed from the system clock, no external baud clock.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_path.sv | 118 +++++++++++
 rtl/uart_transceiver.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
// Both the TX path and the RX path use them.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Clocks per RX sample tick, rounded to the nearest integer.
  function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + baud * oversample / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_path.sv
// UART receive path: rxd synchroniser, oversampling tick counter, RX FSM,
// and the valid/ready delivery stage with framing-error and overrun pulses.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int DIV        = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  rx_state_t            state;
  logic [1:0]           sync;
  logic [TICK_W-1:0]    tick_cnt;
  logic [SAMP_W-1:0]    samp_idx;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;

  logic rxd_s;
  logic tick;
  logic mid_sample;
  logic byte_done;
  logic consume;

  assign rxd_s      = sync[1];
  assign tick       = tick_cnt == TICK_W'(DIV - 1);
  assign mid_sample = tick && (samp_idx == SAMP_W'(OVERSAMPLE / 2 - 1));
  assign byte_done  = (state == RX_STOP) && mid_sample && rxd_s;
  assign consume    = rx_valid && rx_ready;

  // NOTE: every register here uses <= so all reads in this block see the
  // pre-edge value; a blocking assignment would let later statements see
  // the new value and silently reorder the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync         <= 2'b11;  // idle line level, so release never fakes a start bit
      state        <= RX_IDLE;
      tick_cnt     <= '0;
      samp_idx     <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      sync         <= {sync[0], rxd};
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;

      if (state != RX_IDLE) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) samp_idx <= (samp_idx == SAMP_W'(OVERSAMPLE - 1)) ? '0 : samp_idx + 1'b1;
      end

      case (state)
        RX_IDLE: begin
          if (!rxd_s) begin
            state    <= RX_START;
            tick_cnt <= '0;
            samp_idx <= '0;
          end
        end
        RX_START: begin
          if (mid_sample) begin
            state   <= rxd_s ? RX_IDLE : RX_DATA;
            bit_idx <= '0;
          end
        end
        RX_DATA: begin
          if (mid_sample) begin
            shift   <= {rxd_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_W'(DATA_BITS - 1)) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Leave at mid-stop so a slightly fast far end never loses a start bit.
          if (mid_sample) begin
            if (rxd_s) begin
              state <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rxd_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase

      if (byte_done) begin
        if (!rx_valid || consume) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (consume) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// 8N1 UART endpoint: inline bit-timed transmitter plus the uart_rx_path
// receiver, both self-timed from clk.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int DIV        = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int BIT_CYCLES = DIV * OVERSAMPLE;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int BIT_W      = $clog2(DATA_BITS);

  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 bit_end;

  assign bit_end = tx_cnt == CNT_W'(BIT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_ready <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_state != TX_IDLE) tx_cnt <= bit_end ? '0 : tx_cnt + 1'b1;

      case (tx_state)
        TX_IDLE: begin
          txd    <= 1'b1;
          tx_cnt <= '0;
          tx_bit <= '0;
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= TX_START;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_end) begin
            txd      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
            end
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            tx_ready <= 1'b1;
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  uart_rx_path #(
    .DIV        (DIV),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx_path (
    .clk          (clk),
    .rst          (rst),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

endmodule
